// File: rtl/and_chain_if.sv
// Pin bundle between the AND-chain exerciser and its control/loopback side.
// start is a request sampled only in IDLE (abort wins when both are high); done is a one-cycle completion pulse.
interface and_chain_if;
  logic       start;
  logic       abort;
  logic       a_o;
  logic       b_o;
  logic       c_o;
  logic       d_o;
  logic       e_i;
  logic       f_i;
  logic       g_i;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_count;
  logic       first_fail_valid;
  logic [3:0] first_fail_vec;
  logic [2:0] first_fail_mask;

  modport slave (
    input  start, abort, e_i, f_i, g_i,
    output a_o, b_o, c_o, d_o, busy, done, pass, err_count,
           first_fail_valid, first_fail_vec, first_fail_mask
  );

  modport master (
    output start, abort, e_i, f_i, g_i,
    input  a_o, b_o, c_o, d_o, busy, done, pass, err_count,
           first_fail_valid, first_fail_vec, first_fail_mask
  );
endinterface

// File: rtl/and_chain_exerciser.sv
// Walks all 16 input vectors through a four-input AND chain, samples the e/f/g taps
// after a settle delay and records error count plus the first failing vector.
module and_chain_exerciser #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    and_chain_if.slave     bus,
    output logic [1:0]     state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] SAMPLE_PHASE  = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] ADVANCE_PHASE = 4'(SETTLE_CYCLES);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] vec_q;
    logic [3:0] phase_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [4:0] err_q;
    logic       ff_valid_q;
    logic [3:0] ff_vec_q;
    logic [2:0] ff_mask_q;

    logic       start_ok;
    logic       sample_fire;
    logic       exp_e;
    logic       exp_f;
    logic       exp_g;
    logic [2:0] mismatch;
    logic       vec_fail;

    assign start_ok    = (state_q == IDLE) && bus.start && !bus.abort;
    // An abort on the sampling edge discards that sample.
    assign sample_fire = (state_q == RUN) && !bus.abort && (phase_q == SAMPLE_PHASE);

    assign exp_e    = vec_q[3] & vec_q[2];
    assign exp_f    = exp_e & vec_q[1];
    assign exp_g    = exp_f & vec_q[0];
    assign mismatch = {bus.e_i ^ exp_e, bus.f_i ^ exp_f, bus.g_i ^ exp_g};
    assign vec_fail = sample_fire && (mismatch != 3'b000);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_ok) state_d = RUN;
            RUN: begin
                if (bus.abort) state_d = IDLE;
                else if (sample_fire && (vec_q == 4'd15)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q      <= 4'd0;
            phase_q    <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= 5'd0;
            ff_valid_q <= 1'b0;
            ff_vec_q   <= 4'd0;
            ff_mask_q  <= 3'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        vec_q      <= 4'd0;
                        phase_q    <= 4'd0;
                        busy_q     <= 1'b1;
                        pass_q     <= 1'b0;
                        err_q      <= 5'd0;
                        ff_valid_q <= 1'b0;
                        ff_vec_q   <= 4'd0;
                        ff_mask_q  <= 3'd0;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        busy_q  <= 1'b0;
                        vec_q   <= 4'd0;
                        phase_q <= 4'd0;
                    end else begin
                        if (vec_fail) begin
                            err_q <= err_q + 5'd1;
                            if (!ff_valid_q) begin
                                ff_valid_q <= 1'b1;
                                ff_vec_q   <= vec_q;
                                ff_mask_q  <= mismatch;
                            end
                        end
                        if (phase_q == ADVANCE_PHASE) begin
                            phase_q <= 4'd0;
                            vec_q   <= vec_q + 4'd1;
                        end else begin
                            phase_q <= phase_q + 4'd1;
                        end
                    end
                end
                DONE: begin
                    // Vector 15 is held through this cycle; completion is reported on exit.
                    busy_q  <= 1'b0;
                    vec_q   <= 4'd0;
                    phase_q <= 4'd0;
                    if (!bus.abort) begin
                        done_q <= 1'b1;
                        pass_q <= (err_q == 5'd0);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    vec_q   <= 4'd0;
                    phase_q <= 4'd0;
                end
            endcase
        end
    end

    assign bus.a_o              = vec_q[3];
    assign bus.b_o              = vec_q[2];
    assign bus.c_o              = vec_q[1];
    assign bus.d_o              = vec_q[0];
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.err_count        = err_q;
    assign bus.first_fail_valid = ff_valid_q;
    assign bus.first_fail_vec   = ff_vec_q;
    assign bus.first_fail_mask  = ff_mask_q;
    assign state_dbg            = state_q;

endmodule

// File: tb/tb_and_chain_exerciser.sv
// Bench for and_chain_exerciser: loopback chain model with injectable tap faults,
// directed runs, and a done-triggered scoreboard for run results.
module tb_and_chain_exerciser;

  localparam int F_NONE = 0;
  localparam int F_G0   = 1;
  localparam int F_F1   = 2;
  localparam int F_E1   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] state_dbg;
  int         fault = F_NONE;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  logic [13:0] exp_q[$];
  int          exp_cyc_q[$];

  and_chain_if bus ();

  and_chain_exerciser #(.SETTLE_CYCLES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // loopback chain with stuck-at faults on the tap pins
  logic e_w, f_w, g_w;
  assign e_w = bus.a_o & bus.b_o;
  assign f_w = e_w & bus.c_o;
  assign g_w = f_w & bus.d_o;
  assign bus.e_i = (fault == F_E1) ? 1'b1 : e_w;
  assign bus.f_i = (fault == F_F1) ? 1'b1 : f_w;
  assign bus.g_i = (fault == F_G0) ? 1'b0 : g_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [13:0] pack_res(input logic p, input logic [4:0] e, input logic v,
                                           input logic [3:0] vec, input logic [2:0] m);
    return {p, e, v, vec, m};
  endfunction

  function automatic logic [13:0] act_res();
    return {bus.pass, bus.err_count, bus.first_fail_valid, bus.first_fail_vec, bus.first_fail_mask};
  endfunction

  function automatic logic [3:0] stim();
    return {bus.a_o, bus.b_o, bus.c_o, bus.d_o};
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        check("run_result", 32'(act_res()), 32'(exp_q.pop_front()));
        check("done_cycle", cyc, exp_cyc_q.pop_front());
        check("busy_at_done", 32'(bus.busy), 32'd0);
        check("stim_at_done", 32'(stim()), 32'd0);
      end
    end
  end

  // driver tasks; called at a negedge, start is sampled on the next posedge
  task automatic start_run(input logic push, input logic [13:0] exp, output int t0);
    bus.start = 1'b1;
    t0 = cyc + 1;
    if (push) begin
      exp_q.push_back(exp);
      exp_cyc_q.push_back(t0 + 48);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!bus.done && n < 150) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, 32'(bus.done), 32'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_outputs"}, {16'd0, act_res(), bus.busy, bus.done},
          32'd0);
    check({name, "_stim"}, 32'(stim()), 32'd0);
    check({name, "_state"}, 32'(state_dbg), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // fault-free run, stimulus stepping, extra start mid-run ignored
    start_run(1'b1, pack_res(1'b1, 5'd0, 1'b0, 4'd0, 3'b000), t0);
    check("busy_after_start", 32'(bus.busy), 32'd1);
    for (int j = 0; j < 48; j++) begin
      wait_cyc(t0 + j);
      check("stim_step", 32'(stim()), 32'(j / 3));
      if (j == 4) bus.start = 1'b1;
      if (j == 5) bus.start = 1'b0;
    end
    wait_done("ff_run");
    @(negedge clk);

    // fault-free abort sampled at T0+10
    start_run(1'b0, 14'd0, t0);
    wait_cyc(t0 + 9);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_stim", 32'(stim()), 32'd0);
    check("abort_result", 32'(act_res()), 32'(pack_res(1'b0, 5'd0, 1'b0, 4'd0, 3'b000)));
    check("abort_state", 32'(state_dbg), 32'd0);
    repeat (60) @(negedge clk);

    // full run after abort, then next run started at the earliest edge
    start_run(1'b1, pack_res(1'b1, 5'd0, 1'b0, 4'd0, 3'b000), t0);
    wait_done("post_abort_run");
    fault = F_G0;
    start_run(1'b1, pack_res(1'b0, 5'd1, 1'b1, 4'd15, 3'b001), t0);
    check("earliest_start_busy", 32'(bus.busy), 32'd1);
    wait_done("g_stuck0_run");
    @(negedge clk);

    fault = F_F1;
    start_run(1'b1, pack_res(1'b0, 5'd14, 1'b1, 4'd0, 3'b010), t0);
    wait_done("f_stuck1_run");
    @(negedge clk);

    fault = F_E1;
    start_run(1'b1, pack_res(1'b0, 5'd12, 1'b1, 4'd0, 3'b100), t0);
    wait_done("e_stuck1_run");
    @(negedge clk);

    // faulted abort on the vector-3 sampling edge: that sample is dropped
    fault = F_F1;
    start_run(1'b0, 14'd0, t0);
    wait_cyc(t0 + 10);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_partial_result", 32'(act_res()), 32'(pack_res(1'b0, 5'd3, 1'b1, 4'd0, 3'b010)));
    check("abort_partial_busy", 32'(bus.busy), 32'd0);
    repeat (60) @(negedge clk);

    // start and abort together in IDLE
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start_abort_busy", 32'(bus.busy), 32'd0);
    check("start_abort_state", 32'(state_dbg), 32'd0);
    repeat (3) @(negedge clk);
    check("start_abort_busy_later", 32'(bus.busy), 32'd0);

    // asynchronous reset mid-run
    fault = F_E1;
    start_run(1'b0, 14'd0, t0);
    wait_cyc(t0 + 20);
    check("pre_reset_result", 32'(act_res()), 32'(pack_res(1'b0, 5'd7, 1'b1, 4'd0, 3'b100)));
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("mid_run_reset");
    @(negedge clk);
    rst_n = 1'b1;
    fault = F_NONE;
    @(negedge clk);
    start_run(1'b1, pack_res(1'b1, 5'd0, 1'b0, 4'd0, 3'b000), t0);
    wait_done("post_reset_run");
    @(negedge clk);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
